cp0_exc_unit: RTL and testbench

- Coprocessor-0 / exception unit directly downstream of the instruction decoder.
- Consumes the decoder's int_cause, cause_write, exit_kernel and write_c0 strobes plus the current PC.
- Holds STATUS, CAUSE and EPC, plus the user/kernel mode state, and drives the PC redirect and the instruction-kill signal.
- Feeds kernel_mode back to the decoder and serves mfc0 reads.

---
 rtl/cp0_exc_if.sv | 28 ++
 rtl/cp0_exc_unit.sv | 122 ++++++++++++
 tb/tb_cp0_exc_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_if.sv
// Decoder <-> CP0 exception unit bus. The decoder side drives the per-instruction
// strobes and the execute-stage PC. The CP0 side returns mode, read data and redirect.
interface cp0_exc_if;
  logic [31:0] pc;
  logic [2:0]  int_cause;
  logic        cause_write;
  logic        exit_kernel;
  logic        write_c0;
  logic [4:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic        kernel_mode;
  logic [31:0] c0_rdata;
  logic        exc_take;
  logic        instr_kill;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic [31:0] epc;

  modport master (
    output pc, int_cause, cause_write, exit_kernel, write_c0, c0_addr, c0_wdata,
    input  kernel_mode, c0_rdata, exc_take, instr_kill, pc_redirect, pc_target, epc
  );

  modport slave (
    input  pc, int_cause, cause_write, exit_kernel, write_c0, c0_addr, c0_wdata,
    output kernel_mode, c0_rdata, exc_take, instr_kill, pc_redirect, pc_target, epc
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception unit: owns STATUS/CAUSE/EPC and the user/kernel mode.
// It accepts synchronous exceptions from the decoder and a synchronized external irq.
// It drives the PC redirect and instruction kill in the same cycle.
module cp0_exc_unit #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0180,
  parameter int          SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      irq,
  cp0_exc_if.slave  bus
);

  typedef enum logic {USER = 1'b0, KERNEL = 1'b1} state_t;

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  state_t state, state_d;

  logic                   ie, pie, ip;
  logic [2:0]             code;
  logic [31:0]            epc_r;
  logic [SYNC_STAGES-1:0] irq_sync;
  logic                   irq_prev;
  logic                   irq_edge;
  logic                   irq_accept;
  logic                   exc_take;
  logic                   exit_accept;
  logic                   wr_ok;

  // Exception / return decisions, all combinational so the fetch stage redirects in the same cycle
  always_comb begin
    irq_edge    = irq_sync[SYNC_STAGES-1] & ~irq_prev;
    exit_accept = (state == KERNEL) & bus.exit_kernel & ~bus.cause_write;
    irq_accept  = ip & ie & (state == USER) & ~bus.cause_write & ~bus.exit_kernel;
    // Gating with reset keeps kill/redirect quiet while reset is held, even if cause_write is high
    exc_take    = reset & (bus.cause_write | irq_accept);
    wr_ok       = bus.write_c0 & ~exc_take;
  end

  // Outputs toward decoder and fetch
  always_comb begin
    bus.exc_take    = exc_take;
    bus.instr_kill  = exc_take;
    bus.pc_redirect = exc_take | exit_accept;
    bus.pc_target   = exc_take ? EXC_VECTOR : epc_r;
    bus.kernel_mode = (state == KERNEL);
    bus.epc         = epc_r;
  end

  // mfc0 read mux; unmapped indices read zero
  always_comb begin
    bus.c0_rdata = 32'd0;
    case (bus.c0_addr)
      ADDR_STATUS: bus.c0_rdata = {30'd0, pie, ie};
      ADDR_CAUSE:  bus.c0_rdata = {23'd0, ip, 3'd0, code, 2'd0};
      ADDR_EPC:    bus.c0_rdata = epc_r;
      default:     bus.c0_rdata = 32'd0;
    endcase
  end

  // Mode state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= USER;
    else        state <= state_d;
  end

  // Mode next-state: enter kernel on any taken exception, leave only on an accepted return
  always_comb begin
    state_d = state;
    case (state)
      USER:    if (exc_take)    state_d = KERNEL;
      KERNEL:  if (exit_accept) state_d = USER;
      default: state_d = USER;
    endcase
  end

  // irq synchronizer and rising-edge detector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_sync <= '0;
      irq_prev <= 1'b0;
    end else begin
      irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq};
      irq_prev <= irq_sync[SYNC_STAGES-1];
    end
  end

  // STATUS / CAUSE / EPC updates; a taken exception drops any same-cycle movc0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie    <= 1'b0;
      pie   <= 1'b0;
      ip    <= 1'b0;
      code  <= 3'd0;
      epc_r <= 32'd0;
    end else begin
      if (exc_take) begin
        code <= bus.cause_write ? bus.int_cause : 3'b100;
        // A nested exception in kernel keeps the original return point and interrupt state
        if (state == USER) begin
          epc_r <= bus.pc;
          pie   <= ie;
          ie    <= 1'b0;
        end
      end else begin
        if (wr_ok && bus.c0_addr == ADDR_STATUS) begin
          ie  <= bus.c0_wdata[0];
          pie <= bus.c0_wdata[1];
        end
        if (wr_ok && bus.c0_addr == ADDR_EPC) epc_r <= bus.c0_wdata;
        if (exit_accept) ie <= pie;
      end
      // A fresh irq edge beats a software clear in the same cycle
      if (irq_edge)                            ip <= 1'b1;
      else if (wr_ok && bus.c0_addr == ADDR_CAUSE) ip <= bus.c0_wdata[8];
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: a vector table for the single-cycle behaviour,
// followed by hand-written sequences for irq latency, return-then-irq, set/clear races and reset.
module tb_cp0_exc_unit;

  logic clk = 1'b0;
  logic reset;
  logic irq;
  int   n_checks = 0;
  int   n_fail   = 0;

  cp0_exc_if bus ();

  cp0_exc_unit #(.EXC_VECTOR(32'h0000_0180), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .irq   (irq),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  ic;
    logic        cw;
    logic        ek;
    logic        wc;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        x_exc;
    logic        x_red;
    logic [31:0] x_tgt;
    logic        x_km;
    logic [31:0] x_rd;
    logic [31:0] x_epc;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [2:0] ic, input logic cw, input logic ek,
                       input logic wc, input logic [4:0] addr, input logic [31:0] wd);
    bus.pc          = pc;
    bus.int_cause   = ic;
    bus.cause_write = cw;
    bus.exit_kernel = ek;
    bus.write_c0    = wc;
    bus.c0_addr     = addr;
    bus.c0_wdata    = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    //            pc          ic cw ek wc addr wd            exc red tgt           km rd            epc
    tbl[0]  = '{32'h0,      0, 0, 0, 0, 12, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h0};
    tbl[1]  = '{32'h0,      0, 0, 0, 1, 12, 32'h1,        0, 0, 32'h0,   0, 32'h0,   32'h0};
    tbl[2]  = '{32'h40,     1, 1, 0, 0, 12, 32'h0,        1, 1, 32'h180, 0, 32'h1,   32'h0};
    tbl[3]  = '{32'h0,      0, 0, 0, 0, 13, 32'h0,        0, 0, 32'h40,  1, 32'h4,   32'h40};
    tbl[4]  = '{32'h0,      0, 0, 0, 0, 12, 32'h0,        0, 0, 32'h40,  1, 32'h2,   32'h40};
    tbl[5]  = '{32'h0,      0, 0, 0, 1, 14, 32'h44,       0, 0, 32'h40,  1, 32'h40,  32'h40};
    tbl[6]  = '{32'h0,      0, 0, 1, 0, 14, 32'h0,        0, 1, 32'h44,  1, 32'h44,  32'h44};
    tbl[7]  = '{32'h0,      0, 0, 0, 0, 12, 32'h0,        0, 0, 32'h44,  0, 32'h3,   32'h44};
    tbl[8]  = '{32'h100,    2, 1, 0, 0, 12, 32'h0,        1, 1, 32'h180, 0, 32'h3,   32'h44};
    tbl[9]  = '{32'h200,    3, 1, 0, 1, 14, 32'hDEAD,     1, 1, 32'h180, 1, 32'h100, 32'h100};
    tbl[10] = '{32'h0,      0, 0, 0, 0, 13, 32'h0,        0, 0, 32'h100, 1, 32'hC,   32'h100};
    tbl[11] = '{32'h0,      0, 0, 0, 0, 12, 32'h0,        0, 0, 32'h100, 1, 32'h2,   32'h100};
    tbl[12] = '{32'h0,      0, 0, 1, 0, 14, 32'h0,        0, 1, 32'h100, 1, 32'h100, 32'h100};
    tbl[13] = '{32'h0,      0, 0, 0, 0, 12, 32'h0,        0, 0, 32'h100, 0, 32'h3,   32'h100};
    tbl[14] = '{32'h0,      0, 0, 1, 0, 13, 32'h0,        0, 0, 32'h100, 0, 32'hC,   32'h100};
    tbl[15] = '{32'h0,      0, 0, 0, 0, 31, 32'h0,        0, 0, 32'h100, 0, 32'h0,   32'h100};
    tbl[16] = '{32'h0,      0, 0, 0, 1, 13, 32'hFFFFFFFF, 0, 0, 32'h100, 0, 32'hC,   32'h100};
    tbl[17] = '{32'h300,    0, 0, 0, 0, 13, 32'h0,        1, 1, 32'h180, 0, 32'h10C, 32'h100};
    tbl[18] = '{32'h0,      0, 0, 0, 0, 13, 32'h0,        0, 0, 32'h300, 1, 32'h110, 32'h300};
    tbl[19] = '{32'h0,      0, 0, 0, 1, 13, 32'h0,        0, 0, 32'h300, 1, 32'h110, 32'h300};
    tbl[20] = '{32'h0,      0, 0, 1, 0, 13, 32'h0,        0, 1, 32'h300, 1, 32'h10,  32'h300};
    tbl[21] = '{32'h0,      0, 0, 0, 0, 12, 32'h0,        0, 0, 32'h300, 0, 32'h3,   32'h300};

    // Reset with decoder strobes active: outputs must stay quiet
    irq   = 1'b0;
    reset = 1'b0;
    drive(32'h40, 3'd1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h0);
    tick();
    #1;
    chk("rst_exc_take", {31'd0, bus.exc_take}, 32'd0);
    chk("rst_pc_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    chk("rst_kernel_mode", {31'd0, bus.kernel_mode}, 32'd0);
    chk("rst_status", bus.c0_rdata, 32'd0);
    drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd12, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Table: drive, let combinational outputs settle, compare, then clock
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].pc, tbl[i].ic, tbl[i].cw, tbl[i].ek, tbl[i].wc, tbl[i].addr, tbl[i].wd);
      #2;
      chk($sformatf("v%0d_exc_take", i),    {31'd0, bus.exc_take},    {31'd0, tbl[i].x_exc});
      chk($sformatf("v%0d_instr_kill", i),  {31'd0, bus.instr_kill},  {31'd0, tbl[i].x_exc});
      chk($sformatf("v%0d_pc_redirect", i), {31'd0, bus.pc_redirect}, {31'd0, tbl[i].x_red});
      chk($sformatf("v%0d_pc_target", i),   bus.pc_target,            tbl[i].x_tgt);
      chk($sformatf("v%0d_kernel_mode", i), {31'd0, bus.kernel_mode}, {31'd0, tbl[i].x_km});
      chk($sformatf("v%0d_c0_rdata", i),    bus.c0_rdata,             tbl[i].x_rd);
      chk($sformatf("v%0d_epc", i),         bus.epc,                  tbl[i].x_epc);
      tick();
    end

    // irq pulse: IP visible after SYNC_STAGES+1 edges, taken in that same cycle
    drive(32'h500, 3'd0, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0);
    irq = 1'b1;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) irq = 1'b0;
      #1;
      n = k;
      if (bus.c0_rdata[8]) break;
    end
    chk("irq_to_ip_latency", n, 3);
    chk("irq_exc_take", {31'd0, bus.exc_take}, 32'd1);
    chk("irq_pc_target", bus.pc_target, 32'h180);
    tick();
    #1;
    chk("irq_kernel_mode", {31'd0, bus.kernel_mode}, 32'd1);
    chk("irq_epc", bus.epc, 32'h500);
    chk("irq_cause", bus.c0_rdata, 32'h110);

    // Pending IP in kernel is held off; return restores IE and the irq is taken next cycle
    chk("kern_irq_blocked", {31'd0, bus.exc_take}, 32'd0);
    drive(32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 5'd14, 32'h0);
    #1;
    chk("ret_pc_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    chk("ret_pc_target", bus.pc_target, 32'h500);
    chk("ret_no_exc", {31'd0, bus.exc_take}, 32'd0);
    tick();
    drive(32'h600, 3'd0, 1'b0, 1'b0, 1'b0, 5'd12, 32'h0);
    #1;
    chk("ret_user", {31'd0, bus.kernel_mode}, 32'd0);
    chk("ret_status", bus.c0_rdata, 32'h3);
    chk("ret_irq_taken", {31'd0, bus.exc_take}, 32'd1);
    tick();
    #1;
    chk("ret_irq_kernel", {31'd0, bus.kernel_mode}, 32'd1);
    chk("ret_irq_epc", bus.epc, 32'h600);

    // IP software clear, then a set and a clear landing in the same cycle
    drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd13, 32'h0);
    tick();
    bus.write_c0 = 1'b0;
    #1;
    chk("ip_clear", {31'd0, bus.c0_rdata[8]}, 32'd0);
    irq = 1'b1;
    tick();
    tick();
    bus.write_c0 = 1'b1;
    tick();
    bus.write_c0 = 1'b0;
    #1;
    chk("ip_set_wins", {31'd0, bus.c0_rdata[8]}, 32'd1);
    bus.write_c0 = 1'b1;
    tick();
    bus.write_c0 = 1'b0;
    #1;
    chk("ip_clear_no_edge", {31'd0, bus.c0_rdata[8]}, 32'd0);
    irq = 1'b0;

    // Reset mid-kernel with IP set and strobes active
    drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd13, 32'h100);
    tick();
    drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h3);
    tick();
    drive(32'h700, 3'd2, 1'b1, 1'b1, 1'b0, 5'd13, 32'h0);
    #1;
    chk("pre_rst_kernel", {31'd0, bus.kernel_mode}, 32'd1);
    chk("pre_rst_ip", bus.c0_rdata, 32'h110);
    reset = 1'b0;
    #1;
    chk("mid_rst_kernel_mode", {31'd0, bus.kernel_mode}, 32'd0);
    chk("mid_rst_pc_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    chk("mid_rst_exc_take", {31'd0, bus.exc_take}, 32'd0);
    chk("mid_rst_cause", bus.c0_rdata, 32'd0);
    bus.c0_addr = 5'd12;
    #1;
    chk("mid_rst_status", bus.c0_rdata, 32'd0);
    bus.c0_addr = 5'd14;
    #1;
    chk("mid_rst_epc_rd", bus.c0_rdata, 32'd0);
    chk("mid_rst_epc", bus.epc, 32'd0);
    drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    #1;
    chk("post_rst_cause", bus.c0_rdata, 32'd0);
    chk("post_rst_kernel", {31'd0, bus.kernel_mode}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
